// File: rtl/mem_ctrl_fsm.sv
// LOAD/STORE sequencer driving the MAR/MDR/memory and register-file enables.
// Instruction is latched on an accepted start; MFC waits are bounded by TIMEOUT.
module mem_ctrl_fsm #(
  parameter int         INSTR_W  = 16,
  parameter int         FIELD_W  = 6,
  parameter int         NUM_REGS = 4,
  parameter int         TIMEOUT  = 16,
  parameter logic [3:0] OP_LOAD  = 4'b0010,
  parameter logic [3:0] OP_STORE = 4'b0011
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [INSTR_W-1:0]  instruction,
  input  logic                MFC,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                memEN,
  output logic                RW,
  output logic                marIn,
  output logic                mdrWriteEN,
  output logic                mdrReadEN,
  output logic                mdrOut,
  output logic                pcInc,
  output logic [NUM_REGS-1:0] rxOut,
  output logic [NUM_REGS-1:0] rxIn
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_MAR, S_ST_SRC, S_ST_MDRW, S_ST_WAIT,
    S_LD_WAIT, S_LD_RD, S_LD_OUT, S_LD_WB, S_DONE, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [3:0]         op_in;
  logic [FIELD_W-1:0] p1_in, p2_in, p1_q, p2_q;
  logic               is_load_q;

  // Register index i drives bit NUM_REGS-1-i.
  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [FIELD_W-1:0] idx);
    logic [NUM_REGS-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == FIELD_W'(i)) sel[NUM_REGS-1-i] = 1'b1;
    end
    return sel;
  endfunction

  function automatic logic idx_ok(input logic [FIELD_W-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  assign op_in     = instruction[INSTR_W-1 -: 4];
  assign p1_in     = instruction[INSTR_W-5 -: FIELD_W];
  assign p2_in     = instruction[INSTR_W-5-FIELD_W -: FIELD_W];
  assign p1_q      = instr_q[INSTR_W-5 -: FIELD_W];
  assign p2_q      = instr_q[INSTR_W-5-FIELD_W -: FIELD_W];
  assign is_load_q = (instr_q[INSTR_W-1 -: 4] == OP_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Wait counter holds zero outside the wait states, so it is cleared on entry.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          instr_d = instruction;
          if (op_in == OP_LOAD || op_in == OP_STORE) begin
            state_d = (idx_ok(p1_in) && idx_ok(p2_in)) ? S_ADDR : S_ERR;
          end
        end
      end
      S_ADDR:    state_d = S_MAR;
      S_MAR:     state_d = is_load_q ? S_LD_WAIT : S_ST_SRC;
      S_ST_SRC:  state_d = S_ST_MDRW;
      S_ST_MDRW: state_d = S_ST_WAIT;
      S_ST_WAIT, S_LD_WAIT: begin
        if (MFC) begin
          state_d = (state_q == S_ST_WAIT) ? S_DONE : S_LD_RD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LD_RD:   state_d = S_LD_OUT;
      S_LD_OUT:  state_d = S_LD_WB;
      S_LD_WB:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    err        = 1'b0;
    memEN      = 1'b0;
    RW         = 1'b0;
    marIn      = 1'b0;
    mdrWriteEN = 1'b0;
    mdrReadEN  = 1'b0;
    mdrOut     = 1'b0;
    pcInc      = 1'b0;
    rxOut      = '0;
    rxIn       = '0;
    unique case (state_q)
      S_ADDR: begin
        pcInc = 1'b1;
        rxOut = reg_sel(p2_q);
      end
      S_MAR: begin
        marIn = 1'b1;
        rxOut = reg_sel(p2_q);
      end
      S_ST_SRC:  rxOut = reg_sel(p1_q);
      S_ST_MDRW: begin
        mdrWriteEN = 1'b1;
        rxOut      = reg_sel(p1_q);
      end
      S_ST_WAIT: memEN = 1'b1;
      S_LD_WAIT: begin
        memEN = 1'b1;
        RW    = 1'b1;
      end
      S_LD_RD: begin
        memEN     = 1'b1;
        RW        = 1'b1;
        mdrReadEN = 1'b1;
      end
      S_LD_OUT: begin
        mdrOut = 1'b1;
        RW     = 1'b1;
      end
      S_LD_WB: begin
        mdrOut = 1'b1;
        RW     = 1'b1;
        rxIn   = reg_sel(p1_q);
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

endmodule
